regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/rapid_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// Shared definitions for the writeback path.
//   XLEN     : register width
//   wb_req_t : one writeback request {valid, rd, data}
package rapid_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic, purely combinational.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index where the priority search starts (must be < NUM_REQ)
//   grant : one-hot grant, zero when no request is pending
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Walk the requesters starting at ptr, wrapping modulo NUM_REQ;
    // the first pending one wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: picks one of NUM_REQ writeback sources
// per cycle (round-robin) and presents it to the register file one cycle
// later. Requests to x0 are consumed and counted instead of written.
// Optional feature macro: REGFILE_WB_FWD_EN adds forwarding-hit compares.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_req_valid/rd/data       : per-requester writeback request
//   o_req_ready               : per-requester one-hot grant
//   o_wb_valid, o_rd, o_rd_data : registered write port (zero when idle)
//   o_drop_cnt                : saturating count of rd=0 handshakes
//   i_rs1, i_rs2, o_fwd_rs1_hit, o_fwd_rs2_hit : forwarding (macro only)
module regfile_wb_arbiter
  import rapid_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0][4:0]        i_req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [4:0]                     o_rd,
  output logic [XLEN-1:0]                o_rd_data,
  output logic                           o_wb_valid,
  output logic [15:0]                    o_drop_cnt
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [4:0]                     i_rs1,
  input  logic [4:0]                     i_rs2,
  output logic                           o_fwd_rs1_hit,
  output logic                           o_fwd_rs2_hit
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PTR_W-1:0]   rr_ptr_p0;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant_p0;
  wb_req_t            sel_p0;
  logic [15:0]        drop_cnt;
  logic               vld_p1;
  logic [4:0]         rd_p1;
  logic [XLEN-1:0]    data_p1;

  // ---- stage p0: arbitration (combinational) ----
  // Masking with reset keeps ready low, so no handshake happens in reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (i_req_valid & {NUM_REQ{~i_reset}}),
    .ptr   (rr_ptr_p0),
    .grant (grant_p0)
  );

  assign o_req_ready = grant_p0;

  always_comb begin
    rr_ptr_nxt = rr_ptr_p0;
    sel_p0     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_p0[k]) begin
        rr_ptr_nxt   = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
        sel_p0.valid = 1'b1;
        sel_p0.rd    = i_req_rd[k];
        sel_p0.data  = i_req_data[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_p0 <= '0;
      drop_cnt  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      rr_ptr_p0 <= rr_ptr_nxt;
      vld_p1    <= sel_p0.valid && (sel_p0.rd != 5'd0);
      if (sel_p0.valid && (sel_p0.rd == 5'd0))
        drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  // ---- stage p1: output register ----
  // Payload only loads on a handshake; the outputs are zero-gated by the
  // valid flag, so the payload itself needs no reset.
  always_ff @(posedge i_clk) begin
    if (sel_p0.valid) begin
      rd_p1   <= sel_p0.rd;
      data_p1 <= sel_p0.data;
    end
  end

  // Gating with i_reset drops a write that was registered in the cycle
  // just before reset asserted.
  assign o_wb_valid = vld_p1 & ~i_reset;
  assign o_rd       = o_wb_valid ? rd_p1   : 5'd0;
  assign o_rd_data  = o_wb_valid ? data_p1 : '0;
  assign o_drop_cnt = i_reset ? 16'd0 : drop_cnt;

`ifdef REGFILE_WB_FWD_EN
  assign o_fwd_rs1_hit = o_wb_valid && (o_rd == i_rs1) && (i_rs1 != 5'd0);
  assign o_fwd_rs2_hit = o_wb_valid && (o_rd == i_rs2) && (i_rs2 != 5'd0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import rapid_pkg::*;

  localparam int NR = 3;

  logic                      clk;
  logic                      rst;
  logic [NR-1:0]             v;
  logic [NR-1:0][4:0]        rd;
  logic [NR-1:0][XLEN-1:0]   data;
  logic [NR-1:0]             o_req_ready;
  logic [4:0]                o_rd;
  logic [XLEN-1:0]           o_rd_data;
  logic                      o_wb_valid;
  logic [15:0]               o_drop_cnt;
  logic [4:0]                rs1;
  logic [4:0]                rs2;
`ifdef REGFILE_WB_FWD_EN
  logic                      hit1;
  logic                      hit2;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (v),
    .i_req_rd    (rd),
    .i_req_data  (data),
    .o_req_ready (o_req_ready),
    .o_rd        (o_rd),
    .o_rd_data   (o_rd_data),
    .o_wb_valid  (o_wb_valid),
    .o_drop_cnt  (o_drop_cnt)
`ifdef REGFILE_WB_FWD_EN
    ,
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .o_fwd_rs1_hit (hit1),
    .o_fwd_rs2_hit (hit2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    int              stamp;
  } wr_t;

  wr_t wr_q[$];
  int  ptr_m = 0;
  int  drops_m = 0;
  int  wait_m[NR];

  always @(negedge clk) begin
    logic [NR-1:0] exp_g;
    logic          exp_wv;
    logic [4:0]    exp_rd;
    logic [XLEN-1:0] exp_data;
    wr_t           e;
    cyc++;
    if (rst) begin
      wr_q.delete();
      ptr_m   = 0;
      drops_m = 0;
      for (int k = 0; k < NR; k++) wait_m[k] = 0;
      chk("rst_ready", 64'(o_req_ready), 64'd0);
      chk("rst_wb_valid", 64'(o_wb_valid), 64'd0);
      chk("rst_rd", 64'(o_rd), 64'd0);
      chk("rst_rd_data", 64'(o_rd_data), 64'd0);
      chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
`ifdef REGFILE_WB_FWD_EN
      chk("rst_hit1", 64'(hit1), 64'd0);
      chk("rst_hit2", 64'(hit2), 64'd0);
`endif
    end else begin
      // Write side: a handshake from the previous cycle must appear now.
      exp_wv   = (wr_q.size() > 0) && (wr_q[0].stamp == cyc - 1);
      exp_rd   = '0;
      exp_data = '0;
      if (exp_wv) begin
        e        = wr_q.pop_front();
        exp_rd   = e.rd;
        exp_data = e.data;
      end
      chk("wb_valid", 64'(o_wb_valid), 64'(exp_wv));
      chk("wb_rd", 64'(o_rd), 64'(exp_rd));
      chk("wb_rd_data", 64'(o_rd_data), 64'(exp_data));
`ifdef REGFILE_WB_FWD_EN
      chk("fwd_hit1", 64'(hit1), 64'(exp_wv && exp_rd == rs1 && rs1 != 0));
      chk("fwd_hit2", 64'(hit2), 64'(exp_wv && exp_rd == rs2 && rs2 != 0));
`endif
      chk("drop_cnt", 64'(o_drop_cnt), 64'((drops_m > 65535) ? 65535 : drops_m));

      // Grant side: first valid requester at or after the pointer, wrapping.
      exp_g = '0;
      for (int i = 0; i < NR; i++)
        if (v[(ptr_m + i) % NR] && exp_g == '0) exp_g[(ptr_m + i) % NR] = 1'b1;
      chk("ready", 64'(o_req_ready), 64'(exp_g));
      chk("ready_onehot", 64'($countones(o_req_ready) <= 1), 64'd1);

      for (int k = 0; k < NR; k++) begin
        if (exp_g[k]) begin
          ptr_m = (k + 1) % NR;
          if (rd[k] == 5'd0) drops_m++;
          else wr_q.push_back('{rd[k], data[k], cyc});
        end
        if (v[k] && !exp_g[k]) begin
          wait_m[k]++;
          chk("starvation", 64'(wait_m[k] < NR), 64'd1);
        end else begin
          wait_m[k] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NR-1:0] hs;

  // One cycle: note which requesters were granted, then advance past the edge.
  task automatic step();
    @(negedge clk);
    hs = v & o_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int k);
    v[k]    = ($urandom_range(0, 99) < 60);
    rd[k]   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    data[k] = $urandom;
  endtask

  initial begin
    rst = 1'b1; v = '0; rd = '0; data = '0; rs1 = '0; rs2 = '0; hs = '0;
    @(posedge clk); #1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // single request on requester 1
    v[1] = 1'b1; rd[1] = 5'd5; data[1] = 32'hDEADBEEF;
    step();
    v = '0;
    repeat (2) step();

    // all three valid continuously straight out of reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < NR; k++) begin
      v[k] = 1'b1; rd[k] = 5'(k + 1); data[k] = 32'hA000_0000 + k;
    end
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < NR; k++)
        if (hs[k]) begin
          rd[k]   = 5'(((k + 1) * 7 + c) % 31 + 1);
          data[k] = $urandom;
        end
    end
    v = '0;
    step();

    // rd = 0 request is consumed and counted
    v[0] = 1'b1; rd[0] = 5'd0; data[0] = 32'h1234;
    step();
    v = '0;
    repeat (2) step();

    // handshake immediately followed by reset is discarded
    v[2] = 1'b1; rd[2] = 5'd9; data[2] = 32'hCAFE_F00D;
    step();
    v = '0; rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    v = 3'b110; rd[1] = 5'd11; data[1] = 32'h1111; rd[2] = 5'd12; data[2] = 32'h2222;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < NR; k++) if (hs[k]) v[k] = 1'b0;
    end

    // forwarding compare
    v[0] = 1'b1; rd[0] = 5'd7; data[0] = 32'h7777;
    step();
    v = '0; rs1 = 5'd7; rs2 = 5'd0;
    step();
    v[0] = 1'b1; rd[0] = 5'd0; data[0] = 32'h0;
    step();
    v = '0; rs1 = 5'd0;
    step();

    // random traffic; requesters hold until granted
    for (int k = 0; k < NR; k++) new_req(k);
    for (int c = 0; c < 10000; c++) begin
      rs1 = ($urandom_range(0, 1) == 1) ? rd[$urandom_range(0, NR - 1)] : 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      step();
      for (int k = 0; k < NR; k++)
        if (hs[k] || !v[k]) new_req(k);
    end

    // drop counter saturation
    v = '1; rd = '0;
    repeat (65540) step();
    v = '0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
